// File: rtl/stoch_arith_if.sv
// stoch_arith_if: operand/handshake bundle between the host pins and stoch_arith_unit
// master drives en, start, mode, prob_a, prob_b, prob_sel; slave returns busy, valid, result
// sn_tap (stream probe) exists only when STOCH_SN_TAP_EN is defined
interface stoch_arith_if #(
  parameter int PW       = 8,
  parameter int WIN_LOG2 = 8
);
  logic                en;
  logic                start;
  logic [1:0]          mode;
  logic [PW-1:0]       prob_a;
  logic [PW-1:0]       prob_b;
  logic [PW-1:0]       prob_sel;
  logic                busy;
  logic                valid;
  logic [WIN_LOG2:0]   result;
`ifdef STOCH_SN_TAP_EN
  logic                sn_tap;
  modport master (output en, start, mode, prob_a, prob_b, prob_sel, input busy, valid, result, sn_tap);
  modport slave  (input en, start, mode, prob_a, prob_b, prob_sel, output busy, valid, result, sn_tap);
`else
  modport master (output en, start, mode, prob_a, prob_b, prob_sel, input busy, valid, result);
  modport slave  (input en, start, mode, prob_a, prob_b, prob_sel, output busy, valid, result);
`endif
endinterface

// File: rtl/stoch_arith_unit.sv
// stoch_arith_unit: LFSR-driven stochastic add/mul engine with windowed ones-count readback
// ports: clk, rst_n (async, active-high), bus (stoch_arith_if.slave: en/start/mode/probs in,
// busy/valid/result out); STOCH_SN_TAP_EN adds bus.sn_tap, the registered RUN stream bit
module stoch_arith_unit #(
  parameter int                PW       = 8,
  parameter int                LFSR_W   = 31,
  parameter int                WIN_LOG2 = 8,
  parameter logic [LFSR_W-1:0] SEED_A   = 1,
  parameter logic [LFSR_W-1:0] SEED_B   = 2,
  parameter logic [LFSR_W-1:0] SEED_S   = 3
) (
  input logic           clk,
  input logic           rst_n,
  stoch_arith_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2, DONE = 2'd3;
  // feedback tap masks: tap n sits at bit n-1
  localparam logic [63:0] TAPS64 = LFSR_W == 16 ? 64'h0000_B400 :
                                   LFSR_W == 24 ? 64'h00E1_0000 :
                                   LFSR_W == 31 ? 64'h4800_0000 : 64'h8020_0003;
  localparam logic [LFSR_W-1:0] TAPS = TAPS64[LFSR_W-1:0];
  if (LFSR_W != 16 && LFSR_W != 24 && LFSR_W != 31 && LFSR_W != 32) begin : g_bad_lfsr_w
    $error("stoch_arith_unit: LFSR_W must be 16, 24, 31 or 32");
  end
  logic [LFSR_W-1:0]   lfsr_a_q, lfsr_b_q, lfsr_s_q;
  logic [1:0]          state_q, state_d, mode_q;
  logic [PW-1:0]       pa_q, pb_q, ps_q;
  logic                sn_a_q, sn_b_q, sn_s_q, stream, accept, last;
  logic [WIN_LOG2-1:0] win_q;
  logic [WIN_LOG2:0]   count_q, result_q;
  function automatic logic [LFSR_W-1:0] step(input logic [LFSR_W-1:0] x);
    return {x[LFSR_W-2:0], ^(x & TAPS)};
  endfunction
  assign stream = mode_q == 2'b00 ? (sn_s_q ? sn_b_q : sn_a_q) :
                  mode_q == 2'b01 ? sn_a_q & sn_b_q :
                  mode_q == 2'b10 ? ~(sn_a_q ^ sn_b_q) : sn_a_q;
  assign accept = state_q == IDLE && bus.start;
  assign last   = state_q == RUN && &win_q;
  always_comb
    state_d = accept ? PRIME : state_q == PRIME ? RUN : last ? DONE : state_q == DONE ? IDLE : state_q;
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      lfsr_a_q <= SEED_A;
      lfsr_b_q <= SEED_B;
      lfsr_s_q <= SEED_S;
      state_q  <= IDLE;
      mode_q   <= '0;
      pa_q     <= '0;
      pb_q     <= '0;
      ps_q     <= '0;
      sn_a_q   <= 1'b0;
      sn_b_q   <= 1'b0;
      sn_s_q   <= 1'b0;
      win_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else if (bus.en) begin
      lfsr_a_q <= step(lfsr_a_q);
      lfsr_b_q <= step(lfsr_b_q);
      lfsr_s_q <= step(lfsr_s_q);
      sn_a_q   <= lfsr_a_q[PW-1:0] < pa_q;
      sn_b_q   <= lfsr_b_q[PW-1:0] < pb_q;
      sn_s_q   <= lfsr_s_q[PW-1:0] < ps_q;
      state_q  <= state_d;
      if (accept) begin
        mode_q  <= bus.mode;
        pa_q    <= bus.prob_a;
        pb_q    <= bus.prob_b;
        ps_q    <= bus.prob_sel;
        win_q   <= '0;
        count_q <= '0;
      end
      if (state_q == RUN) begin
        win_q   <= win_q + WIN_LOG2'(1);
        count_q <= count_q + (WIN_LOG2+1)'(stream);
      end
      // publish the final sum on entry to DONE so result is current while valid is high
      if (last) result_q <= count_q + (WIN_LOG2+1)'(stream);
    end
  assign bus.busy   = state_q != IDLE;
  assign bus.valid  = state_q == DONE && bus.en;
  assign bus.result = result_q;
`ifdef STOCH_SN_TAP_EN
  logic sn_tap_q;
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) sn_tap_q <= 1'b0;
    else if (bus.en) sn_tap_q <= state_q == RUN && stream;
  assign bus.sn_tap = sn_tap_q;
`endif
endmodule

// File: tb/tb_stoch_arith_unit.sv
// tb_stoch_arith_unit: directed scoreboard bench with an independent LFSR/stream reference model
module tb_stoch_arith_unit;
  localparam int WIN = 256;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  stoch_arith_if io ();
  stoch_arith_unit dut (.clk(clk), .rst_n(rst_n), .bus(io));
  int checks = 0;
  int errors = 0;
  int exp_q[$];
  logic [30:0] m_a, m_b, m_s;
  int r1, r2, n;
  function automatic logic [30:0] nx(input logic [30:0] x);
    return {x[29:0], x[30] ^ x[27]};
  endfunction
  always @(posedge clk or posedge rst_n)
    if (rst_n) begin
      m_a <= 31'd1;
      m_b <= 31'd2;
      m_s <= 31'd3;
    end else if (io.en) begin
      m_a <= nx(m_a);
      m_b <= nx(m_b);
      m_s <= nx(m_s);
    end
  function automatic int model(input logic [1:0] md, input logic [7:0] pa, pb, ps);
    logic [30:0] a = m_a;
    logic [30:0] b = m_b;
    logic [30:0] s = m_s;
    int c = 0;
    for (int k = 0; k < WIN; k++) begin
      logic sa, sb, ss, bv;
      sa = a[7:0] < pa;
      sb = b[7:0] < pb;
      ss = s[7:0] < ps;
      bv = md == 2'd0 ? (ss ? sb : sa) : md == 2'd1 ? (sa & sb) : md == 2'd2 ? ~(sa ^ sb) : sa;
      c += int'(bv);
      a = nx(a);
      b = nx(b);
      s = nx(s);
    end
    return c;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask
  task automatic go(input logic [1:0] md, input logic [7:0] pa, pb, ps);
    io.mode = md;
    io.prob_a = pa;
    io.prob_b = pb;
    io.prob_sel = ps;
    io.en = 1'b1;
    io.start = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    exp_q.push_back(model(md, pa, pb, ps));
    io.mode = ~md;
    io.prob_a = ~pa;
    io.prob_b = ~pb;
    io.prob_sel = ~ps;
  endtask
  task automatic wait_valid(input string tag, input bit tog, input bit poke, output int res);
    int l = 0;
    int c = 0;
    bit got = 1'b0;
    res = -1;
    while (!got && c < 3000) begin
      io.en = tog ? c[0] : 1'b1;
      if (poke) io.start = (c == 40);
      @(negedge clk);
      if (io.en && io.valid) begin
        got = 1'b1;
        res = int'(io.result);
        chk({tag, " latency"}, l, WIN + 1);
        chk({tag, " queue nonempty"}, exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk({tag, " result"}, res, exp_q.pop_front());
      end else if (!io.en) chk({tag, " valid gated by en"}, io.valid, 0);
      @(posedge clk); #1;
      if (io.en) l++;
      c++;
    end
    chk({tag, " valid seen"}, got, 1);
    io.en = 1'b1;
    io.start = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    io.en = 1'b1;
    io.start = 1'b0;
    io.mode = 2'd0;
    io.prob_a = '0;
    io.prob_b = '0;
    io.prob_sel = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    chk("reset busy", io.busy, 0);
    chk("reset valid", io.valid, 0);
    chk("reset result", io.result, 0);
    chk("reset lfsr_a", dut.lfsr_a_q, 1);
`ifdef STOCH_SN_TAP_EN
    chk("reset sn_tap", io.sn_tap, 0);
`endif
    go(2'b11, 8'd0, 8'd0, 8'd0);
    chk("t1 busy after start", io.busy, 1);
    wait_valid("t1", 1'b0, 1'b0, r1);
    chk("t1 pass zero", r1, 0);
    go(2'b10, 8'd0, 8'd0, 8'd0);
    wait_valid("t2", 1'b0, 1'b0, r1);
    chk("t2 xnor full window", r1, WIN);
    repeat (3000) @(posedge clk);
    #1;
    go(2'b00, 8'd128, 8'd0, 8'd0);
    wait_valid("t3a", 1'b0, 1'b0, r1);
    chk_rng("t3a mux add range", r1, 104, 152);
    go(2'b00, 8'd128, 8'd0, 8'd0);
    wait_valid("t3b", 1'b0, 1'b0, r2);
    chk_rng("t3b mux add range", r2, 104, 152);
    go(2'b01, 8'hFF, 8'hFF, 8'd0);
    wait_valid("t4", 1'b0, 1'b1, r1);
    chk_rng("t4 and mul high", r1, 248, WIN);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (io.valid) n++;
    end
    #1;
    chk("t4 no extra valid", n, 0);
    chk("t4 idle after window", io.busy, 0);
    chk("t4 result held", io.result, r1);
    do_reset();
    go(2'b10, 8'd100, 8'd200, 8'd0);
    wait_valid("t5a", 1'b0, 1'b0, r1);
    do_reset();
    go(2'b10, 8'd100, 8'd200, 8'd0);
    wait_valid("t5b", 1'b1, 1'b0, r2);
    chk("t5 en-toggled equals en=1", r2, r1);
    go(2'b00, 8'd128, 8'd64, 8'd128);
    repeat (100) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("t6 busy", io.busy, 0);
    chk("t6 valid", io.valid, 0);
    chk("t6 result", io.result, 0);
    chk("t6 lfsr_a", dut.lfsr_a_q, 1);
    chk("t6 lfsr_b", dut.lfsr_b_q, 2);
    chk("t6 lfsr_s", dut.lfsr_s_q, 3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    go(2'b01, 8'd200, 8'd150, 8'd0);
    wait_valid("t6 restart", 1'b0, 1'b0, r1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
